// File: rtl/mic_fir_scheduler.sv
// Shares one interleaved FIR across NUM_CH microphone channels: snapshots the newest
// sample of each mic per audio frame, streams them in channel order, and demuxes the results.
module mic_fir_scheduler #(
  parameter int NUM_CH = 3,
  parameter int WIDTH  = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    frame_trigger,
  input  logic [NUM_CH-1:0]       sample_valid_in,
  input  logic [NUM_CH*WIDTH-1:0] sample_in,
  output logic                    fir_tvalid_out,
  input  logic                    fir_tready_in,
  output logic [WIDTH-1:0]        fir_tdata_out,
  output logic                    fir_tlast_out,
  input  logic                    fir_tvalid_in,
  input  logic [WIDTH-1:0]        fir_tdata_in,
  output logic [NUM_CH*WIDTH-1:0] filtered_out,
  output logic                    filtered_valid_out,
  output logic [NUM_CH-1:0]       stale_out,
  output logic                    overrun_out
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic {S_IDLE, S_SEND} state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   tx_ch_q, tx_ch_d;
  logic [CH_W-1:0]   rx_ch_q, rx_ch_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] stale_q, stale_d;
  logic              overrun_q, overrun_d;
  logic [WIDTH-1:0]  hold_q [NUM_CH];
  logic [WIDTH-1:0]  hold_d [NUM_CH];
  logic [WIDTH-1:0]  buf_q  [NUM_CH];
  logic [WIDTH-1:0]  buf_d  [NUM_CH];
  logic [WIDTH-1:0]  filt_q [NUM_CH];
  logic [WIDTH-1:0]  filt_d [NUM_CH];
  logic              tvalid_q, tvalid_d;
  logic [WIDTH-1:0]  tdata_q, tdata_d;
  logic              tlast_q, tlast_d;
  logic              fvalid_q, fvalid_d;

  always_comb begin
    // NOTE: every _d gets a default before any branch, so no path can infer a latch.
    state_d   = state_q;
    tx_ch_d   = tx_ch_q;
    rx_ch_d   = rx_ch_q;
    pending_d = pending_q | sample_valid_in;
    stale_d   = stale_q;
    overrun_d = overrun_q;
    hold_d    = hold_q;
    buf_d     = buf_q;
    filt_d    = filt_q;
    fvalid_d  = 1'b0;

    for (int k = 0; k < NUM_CH; k++) begin
      if (sample_valid_in[k]) hold_d[k] = sample_in[WIDTH*k +: WIDTH];
    end

    case (state_q)
      S_IDLE: begin
        if (frame_trigger) begin
          // Snapshot from hold_d so a strobe coinciding with the trigger is included.
          buf_d     = hold_d;
          stale_d   = ~(pending_q | sample_valid_in);
          pending_d = '0;
          tx_ch_d   = '0;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (frame_trigger) overrun_d = 1'b1;
        if (fir_tready_in) begin
          if (tx_ch_q == LAST_CH) begin
            tx_ch_d = '0;
            state_d = S_IDLE;
          end else begin
            tx_ch_d = tx_ch_q + CH_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    tvalid_d = (state_d == S_SEND);
    tdata_d  = tvalid_d ? buf_d[tx_ch_d] : '0;
    tlast_d  = tvalid_d && (tx_ch_d == LAST_CH);

    // Output demux runs on its own counter; the FIR never backpressures its master port.
    if (fir_tvalid_in) begin
      filt_d[rx_ch_q] = fir_tdata_in;
      fvalid_d        = (rx_ch_q == LAST_CH);
      rx_ch_d         = (rx_ch_q == LAST_CH) ? '0 : rx_ch_q + CH_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      tx_ch_q   <= '0;
      rx_ch_q   <= '0;
      pending_q <= '0;
      stale_q   <= '0;
      overrun_q <= 1'b0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      tlast_q   <= 1'b0;
      fvalid_q  <= 1'b0;
      // NOTE: the sample arrays are tiny and must restart from zero after a mid-frame
      // reset to keep FIR phase and resent values deterministic, so they are reset too.
      for (int k = 0; k < NUM_CH; k++) begin
        hold_q[k] <= '0;
        buf_q[k]  <= '0;
        filt_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge _d values.
      state_q   <= state_d;
      tx_ch_q   <= tx_ch_d;
      rx_ch_q   <= rx_ch_d;
      pending_q <= pending_d;
      stale_q   <= stale_d;
      overrun_q <= overrun_d;
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
      tlast_q   <= tlast_d;
      fvalid_q  <= fvalid_d;
      hold_q    <= hold_d;
      buf_q     <= buf_d;
      filt_q    <= filt_d;
    end
  end

  always_comb begin
    filtered_out = '0;
    for (int k = 0; k < NUM_CH; k++) filtered_out[WIDTH*k +: WIDTH] = filt_q[k];
  end

  assign fir_tvalid_out     = tvalid_q;
  assign fir_tdata_out      = tdata_q;
  assign fir_tlast_out      = tlast_q;
  assign filtered_valid_out = fvalid_q;
  assign stale_out          = stale_q;
  assign overrun_out        = overrun_q;

endmodule

// File: tb/tb_mic_fir_scheduler.sv
// Scoreboard bench for mic_fir_scheduler: expected FIR beats and filtered frames are
// queued as stimulus is driven and popped by negedge monitors.
module tb_mic_fir_scheduler;

  localparam int NUM_CH = 3;
  localparam int WIDTH  = 16;

  logic                    clk_in = 1'b0;
  logic                    rst_in;
  logic                    frame_trigger;
  logic [NUM_CH-1:0]       sample_valid_in;
  logic [NUM_CH*WIDTH-1:0] sample_in;
  logic                    fir_tvalid_out;
  logic                    fir_tready_in;
  logic [WIDTH-1:0]        fir_tdata_out;
  logic                    fir_tlast_out;
  logic                    fir_tvalid_in;
  logic [WIDTH-1:0]        fir_tdata_in;
  logic [NUM_CH*WIDTH-1:0] filtered_out;
  logic                    filtered_valid_out;
  logic [NUM_CH-1:0]       stale_out;
  logic                    overrun_out;

  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH:0]          exp_beats  [$];
  logic [NUM_CH*WIDTH-1:0] exp_frames [$];

  mic_fir_scheduler #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .frame_trigger      (frame_trigger),
    .sample_valid_in    (sample_valid_in),
    .sample_in          (sample_in),
    .fir_tvalid_out     (fir_tvalid_out),
    .fir_tready_in      (fir_tready_in),
    .fir_tdata_out      (fir_tdata_out),
    .fir_tlast_out      (fir_tlast_out),
    .fir_tvalid_in      (fir_tvalid_in),
    .fir_tdata_in       (fir_tdata_in),
    .filtered_out       (filtered_out),
    .filtered_valid_out (filtered_valid_out),
    .stale_out          (stale_out),
    .overrun_out        (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  // Handshakes complete at the next posedge with the values seen here.
  always @(negedge clk_in) begin
    if (!rst_in && fir_tvalid_out && fir_tready_in) begin
      n_vec++;
      if (exp_beats.size() == 0) begin
        n_err++;
        $display("FAIL beat_unexpected: got data=%h last=%b, expected no beat", fir_tdata_out, fir_tlast_out);
      end else begin
        logic [WIDTH:0] e;
        e = exp_beats.pop_front();
        if ({fir_tlast_out, fir_tdata_out} !== e) begin
          n_err++;
          $display("FAIL beat: got last=%b data=%h, expected last=%b data=%h",
                   fir_tlast_out, fir_tdata_out, e[WIDTH], e[WIDTH-1:0]);
        end
      end
    end
    if (!rst_in && filtered_valid_out) begin
      n_vec++;
      if (exp_frames.size() == 0) begin
        n_err++;
        $display("FAIL frame_unexpected: got filtered=%h, expected no pulse", filtered_out);
      end else begin
        logic [NUM_CH*WIDTH-1:0] f;
        f = exp_frames.pop_front();
        if (filtered_out !== f) begin
          n_err++;
          $display("FAIL frame: got filtered=%h, expected %h", filtered_out, f);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic load_samples(input logic [WIDTH-1:0] s0, s1, s2);
    sample_valid_in = 3'b111;
    sample_in       = {s2, s1, s0};
    cyc();
    sample_valid_in = '0;
  endtask

  task automatic push_frame(input logic [WIDTH-1:0] s0, s1, s2);
    exp_beats.push_back({1'b0, s0});
    exp_beats.push_back({1'b0, s1});
    exp_beats.push_back({1'b1, s2});
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 64 && fir_tvalid_out; i++) cyc();
    n_vec++;
    if (fir_tvalid_out !== 1'b0) begin
      n_err++;
      $display("FAIL %s_timeout: tvalid=%b after 64 cycles, expected 0", tag, fir_tvalid_out);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    cyc();
    cyc();
    n_vec++;
    if ({fir_tvalid_out, fir_tlast_out, filtered_valid_out, overrun_out} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b, expected 0000",
               {fir_tvalid_out, fir_tlast_out, filtered_valid_out, overrun_out});
    end
    n_vec++;
    if (fir_tdata_out !== '0 || filtered_out !== '0 || stale_out !== '0) begin
      n_err++;
      $display("FAIL reset_data: got tdata=%h filtered=%h stale=%b, expected zeros",
               fir_tdata_out, filtered_out, stale_out);
    end
    rst_in = 1'b0;
    cyc();
  endtask

  task automatic test_fresh_samples();
    load_samples(16'h1111, 16'h2222, 16'h3333);
    frame_trigger = 1'b1;
    push_frame(16'h1111, 16'h2222, 16'h3333);
    cyc();
    frame_trigger = 1'b0;
    n_vec++;
    if (!(fir_tvalid_out === 1'b1 && fir_tdata_out === 16'h1111 && fir_tlast_out === 1'b0)) begin
      n_err++;
      $display("FAIL fresh_t1: got v=%b d=%h l=%b, expected v=1 d=1111 l=0",
               fir_tvalid_out, fir_tdata_out, fir_tlast_out);
    end
    n_vec++;
    if (stale_out !== 3'b000) begin
      n_err++;
      $display("FAIL fresh_stale: got %b, expected 000", stale_out);
    end
    cyc();
    n_vec++;
    if (fir_tdata_out !== 16'h2222 || fir_tlast_out !== 1'b0) begin
      n_err++;
      $display("FAIL fresh_t2: got d=%h l=%b, expected d=2222 l=0", fir_tdata_out, fir_tlast_out);
    end
    cyc();
    n_vec++;
    if (fir_tdata_out !== 16'h3333 || fir_tlast_out !== 1'b1) begin
      n_err++;
      $display("FAIL fresh_t3: got d=%h l=%b, expected d=3333 l=1", fir_tdata_out, fir_tlast_out);
    end
    cyc();
    n_vec++;
    if (fir_tvalid_out !== 1'b0) begin
      n_err++;
      $display("FAIL fresh_t4: got tvalid=%b, expected 0", fir_tvalid_out);
    end
  endtask

  task automatic test_backpressure();
    load_samples(16'h1111, 16'h2222, 16'h3333);
    frame_trigger = 1'b1;
    push_frame(16'h1111, 16'h2222, 16'h3333);
    cyc();
    frame_trigger = 1'b0;
    cyc();
    fir_tready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (fir_tvalid_out !== 1'b1 || fir_tdata_out !== 16'h2222) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h, expected v=1 d=2222", i, fir_tvalid_out, fir_tdata_out);
      end
      cyc();
    end
    fir_tready_in = 1'b1;
    cyc();
    n_vec++;
    if (fir_tdata_out !== 16'h3333 || fir_tlast_out !== 1'b1) begin
      n_err++;
      $display("FAIL bp_ch2: got d=%h l=%b, expected d=3333 l=1", fir_tdata_out, fir_tlast_out);
    end
    wait_idle("bp");
    n_vec++;
    if (exp_beats.size() != 0) begin
      n_err++;
      $display("FAIL bp_count: %0d beats outstanding, expected 0", exp_beats.size());
    end
  endtask

  task automatic test_stale_bypass();
    sample_valid_in = 3'b001;
    sample_in       = {16'hDEAD, 16'hDEAD, 16'h4444};
    cyc();
    sample_valid_in = 3'b100;
    sample_in       = {16'h7FFF, 16'hBEEF, 16'hBEEF};
    frame_trigger   = 1'b1;
    push_frame(16'h4444, 16'h2222, 16'h7FFF);
    cyc();
    sample_valid_in = '0;
    frame_trigger   = 1'b0;
    n_vec++;
    if (stale_out !== 3'b010) begin
      n_err++;
      $display("FAIL stale_flags: got %b, expected 010", stale_out);
    end
    wait_idle("stale");
  endtask

  task automatic test_demux();
    fir_tvalid_in = 1'b1;
    fir_tdata_in  = 16'hAAAA;
    cyc();
    fir_tvalid_in = 1'b0;
    n_vec++;
    if (filtered_out[15:0] !== 16'hAAAA || filtered_valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL demux_slot0: got slot0=%h pulse=%b, expected AAAA 0", filtered_out[15:0], filtered_valid_out);
    end
    cyc();
    fir_tvalid_in = 1'b1;
    fir_tdata_in  = 16'hBBBB;
    cyc();
    fir_tvalid_in = 1'b0;
    cyc();
    fir_tvalid_in = 1'b1;
    fir_tdata_in  = 16'h8000;
    exp_frames.push_back({16'h8000, 16'hBBBB, 16'hAAAA});
    cyc();
    fir_tvalid_in = 1'b0;
    n_vec++;
    if (filtered_valid_out !== 1'b1 || filtered_out !== {16'h8000, 16'hBBBB, 16'hAAAA}) begin
      n_err++;
      $display("FAIL demux_frame: got pulse=%b filtered=%h, expected 1 8000bbbbaaaa", filtered_valid_out, filtered_out);
    end
    cyc();
    n_vec++;
    if (filtered_valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL demux_pulse_width: got %b, expected 0", filtered_valid_out);
    end
  endtask

  task automatic test_back_to_back();
    load_samples(16'h1010, 16'h2020, 16'h3030);
    frame_trigger = 1'b1;
    push_frame(16'h1010, 16'h2020, 16'h3030);
    cyc();
    frame_trigger = 1'b0;
    fir_tvalid_in = 1'b1;
    fir_tdata_in  = 16'h0101;
    cyc();
    fir_tdata_in  = 16'h0202;
    cyc();
    fir_tdata_in  = 16'h0303;
    exp_frames.push_back({16'h0303, 16'h0202, 16'h0101});
    cyc();
    fir_tvalid_in = 1'b0;
    n_vec++;
    if (fir_tvalid_out !== 1'b0 || filtered_valid_out !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_t4: got tvalid=%b pulse=%b, expected 0 1", fir_tvalid_out, filtered_valid_out);
    end
    frame_trigger = 1'b1;
    push_frame(16'h1010, 16'h2020, 16'h3030);
    cyc();
    frame_trigger = 1'b0;
    n_vec++;
    if (fir_tvalid_out !== 1'b1 || fir_tdata_out !== 16'h1010 || stale_out !== 3'b111 || overrun_out !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_t5: got v=%b d=%h stale=%b ovr=%b, expected 1 1010 111 0",
               fir_tvalid_out, fir_tdata_out, stale_out, overrun_out);
    end
    wait_idle("b2b");
  endtask

  task automatic test_overrun();
    int extra;
    fir_tready_in = 1'b0;
    frame_trigger = 1'b1;
    push_frame(16'h1010, 16'h2020, 16'h3030);
    cyc();
    frame_trigger = 1'b0;
    n_vec++;
    if (fir_tvalid_out !== 1'b1 || overrun_out !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_start: got v=%b ovr=%b, expected 1 0", fir_tvalid_out, overrun_out);
    end
    cyc();
    frame_trigger = 1'b1;
    cyc();
    frame_trigger = 1'b0;
    n_vec++;
    if (overrun_out !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_set: got %b, expected 1", overrun_out);
    end
    repeat (3) cyc();
    fir_tready_in = 1'b1;
    wait_idle("ovr");
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      if (fir_tvalid_out) extra++;
      cyc();
    end
    n_vec++;
    if (extra != 0 || exp_beats.size() != 0 || overrun_out !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_after: got extra_valid=%0d outstanding=%0d ovr=%b, expected 0 0 1",
               extra, exp_beats.size(), overrun_out);
    end
    frame_trigger = 1'b1;
    push_frame(16'h1010, 16'h2020, 16'h3030);
    cyc();
    frame_trigger = 1'b0;
    n_vec++;
    if (fir_tvalid_out !== 1'b1 || fir_tdata_out !== 16'h1010) begin
      n_err++;
      $display("FAIL ovr_restart: got v=%b d=%h, expected 1 1010", fir_tvalid_out, fir_tdata_out);
    end
    wait_idle("ovr_restart");
  endtask

  task automatic test_reset_mid_frame();
    load_samples(16'h5555, 16'h6666, 16'h7777);
    fir_tvalid_in = 1'b1;
    fir_tdata_in  = 16'hDEAD;
    frame_trigger = 1'b1;
    push_frame(16'h5555, 16'h6666, 16'h7777);
    cyc();
    fir_tvalid_in = 1'b0;
    frame_trigger = 1'b0;
    cyc();
    rst_in = 1'b1;
    cyc();
    exp_beats.delete();
    n_vec++;
    if ({fir_tvalid_out, fir_tlast_out, filtered_valid_out, overrun_out} !== 4'b0 ||
        fir_tdata_out !== '0 || filtered_out !== '0 || stale_out !== '0) begin
      n_err++;
      $display("FAIL rst_mid: got v=%b l=%b fv=%b ovr=%b d=%h filt=%h stale=%b, expected all 0",
               fir_tvalid_out, fir_tlast_out, filtered_valid_out, overrun_out,
               fir_tdata_out, filtered_out, stale_out);
    end
    rst_in = 1'b0;
    cyc();
    load_samples(16'h0123, 16'h4567, 16'h89AB);
    frame_trigger = 1'b1;
    push_frame(16'h0123, 16'h4567, 16'h89AB);
    cyc();
    frame_trigger = 1'b0;
    n_vec++;
    if (fir_tvalid_out !== 1'b1 || fir_tdata_out !== 16'h0123 || stale_out !== 3'b000) begin
      n_err++;
      $display("FAIL rst_restart: got v=%b d=%h stale=%b, expected 1 0123 000",
               fir_tvalid_out, fir_tdata_out, stale_out);
    end
    wait_idle("rst_restart");
    fir_tvalid_in = 1'b1;
    fir_tdata_in  = 16'hC001;
    cyc();
    fir_tdata_in  = 16'hC002;
    cyc();
    fir_tdata_in  = 16'hC003;
    exp_frames.push_back({16'hC003, 16'hC002, 16'hC001});
    cyc();
    fir_tvalid_in = 1'b0;
    n_vec++;
    if (filtered_valid_out !== 1'b1 || filtered_out !== {16'hC003, 16'hC002, 16'hC001}) begin
      n_err++;
      $display("FAIL rst_rx_phase: got pulse=%b filtered=%h, expected 1 c003c002c001",
               filtered_valid_out, filtered_out);
    end
    cyc();
  endtask

  initial begin
    rst_in          = 1'b1;
    frame_trigger   = 1'b0;
    sample_valid_in = '0;
    sample_in       = '0;
    fir_tready_in   = 1'b1;
    fir_tvalid_in   = 1'b0;
    fir_tdata_in    = '0;

    test_reset();
    test_fresh_samples();
    test_backpressure();
    test_stale_bypass();
    test_demux();
    test_back_to_back();
    test_overrun();
    test_reset_mid_frame();

    n_vec++;
    if (exp_beats.size() != 0 || exp_frames.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d beats and %0d frames outstanding, expected 0 0",
               exp_beats.size(), exp_frames.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mic_fir_scheduler.md
# mic_fir_scheduler

Time-multiplexes one shared anti-aliasing FIR across all three I2S microphone channels, replacing one filter instance per mic. The block captures each mic's newest sample and, once per 48 kHz audio frame, issues one AXI-Stream beat per channel in fixed order 0,1,2 to a FIR configured for 3 interleaved channels. It then demultiplexes the filter's output beats back into per-channel registers. It sits between the `i2s` instances and the `sos_dist_calculator` / `delayed_sound_out` consumers.

## Interface

Parameters:
- NUM_CH, 3, number of interleaved channels; must match the FIR channel configuration.
- WIDTH, 16, sample width in bits; samples are signed two's complement.

Ports:
- clk_in  input  1  audio clock (98.3 MHz)
- rst_in  input  1  reset; synchronous, active-high
- frame_trigger  input  1  one-cycle 48 kHz frame strobe (`audio_trigger`)
- sample_valid_in  input  NUM_CH  per-channel one-cycle new-sample strobe from `i2s`
- sample_in  input  NUM_CH*WIDTH  channel k occupies bits [WIDTH*k+WIDTH-1 : WIDTH*k]
- fir_tvalid_out  output  1  AXI-S valid to FIR slave port
- fir_tready_in  input  1  AXI-S ready from FIR
- fir_tdata_out  output  WIDTH  AXI-S data to FIR
- fir_tlast_out  output  1  high on the channel NUM_CH-1 beat
- fir_tvalid_in  input  1  FIR master valid; no backpressure
- fir_tdata_in  input  WIDTH  FIR master data
- filtered_out  output  NUM_CH*WIDTH  latest filtered sample per channel, same packing as `sample_in`
- filtered_valid_out  output  1  one-cycle pulse when a complete frame of filtered samples has been written
- stale_out  output  NUM_CH  bit k = channel k was resent without a fresh sample in the last frame
- overrun_out  output  1  sticky flag: frame_trigger arrived while a frame was still being sent

## Operation

- Hold register per channel:
  - loads `sample_in` slice k on `sample_valid_in[k]`.
  - pending[k] is set by that strobe.
- Input FSM, states IDLE and SEND; channel index tx_ch ranges 0..NUM_CH-1.
  - IDLE with frame_trigger=1:
    - snapshot all hold registers into the send buffer.
    - a `sample_valid_in[k]` on the same cycle bypasses into the snapshot and counts as fresh.
    - `stale_out[k]` <= ~(pending[k] | sample_valid_in[k]); clear all pending.
    - tx_ch <= 0; go to SEND.
  - SEND:
    - `fir_tvalid_out`=1; `fir_tdata_out` = buffer[tx_ch]; `fir_tlast_out` = (tx_ch==NUM_CH-1).
    - data is held stable while tready=0.
    - on tvalid&tready: tx_ch++; after the NUM_CH-1 beat, go to IDLE.
  - A missing channel sample is never skipped; its old value is resent so the FIR interleave never slips.
- Overrun:
  - frame_trigger in SEND, including the cycle of the final handshake, sets `overrun_out`.
  - that trigger is dropped; the frame in flight completes unchanged.
  - `overrun_out` is cleared only by rst_in.
- Output demux:
  - rx_ch counter 0..NUM_CH-1, independent of tx_ch.
  - each fir_tvalid_in writes `fir_tdata_in` into slot rx_ch, then rx_ch wraps NUM_CH-1 -> 0.
  - when slot NUM_CH-1 is written, `filtered_valid_out` <= 1 for one cycle.
- Input and output paths run concurrently; output beats may arrive while SEND is active.
- No arithmetic on samples: pure routing, width preserved.

## Timing

- Reset values:
  - `fir_tvalid_out`, `fir_tlast_out`, `filtered_valid_out`, `overrun_out`: 0.
  - `fir_tdata_out`, `filtered_out`, `stale_out`: all zero.
  - internally: FSM IDLE; tx_ch, rx_ch, pending, hold and buffer registers all 0.
- rst_in mid-frame:
  - next cycle `fir_tvalid_out`=0 and all state is at reset values.
  - the FIR must be reset on the same rst_in so the channel phase stays aligned.
- Latency, trigger to first beat: frame_trigger high at cycle T puts `fir_tvalid_out`=1 with ch0 at T+1.
- With tready constantly high:
  - beats ch0, ch1, ch2 on T+1, T+2, T+3.
  - `fir_tvalid_out`=0 at T+4.
  - a trigger accepted at the earliest at T+4.
- Output side latency: `filtered_out` slot update and `filtered_valid_out` appear one cycle after the capturing fir_tvalid_in cycle.
- Backpressure: a beat is held indefinitely while tready=0; throughput is 1 beat/cycle when tready=1.
- Budget: 2048 cycles per frame, so overrun only occurs under pathological backpressure.

## Test plan

- Fresh samples per channel and tready=1:
  - stimulus: ch0/1/2 strobes with 0x1111/0x2222/0x3333, then frame_trigger at T.
  - response: beats 0x1111, 0x2222, 0x3333 at T+1..T+3; tlast only at T+3; `stale_out`=000.
- Backpressure:
  - stimulus: tready low for 5 cycles mid-frame on ch1.
  - response: `fir_tdata_out` stays 0x2222 with tvalid high; ch2 follows the first ready cycle; no beat lost or duplicated.
- Stale channel and bypass:
  - stimulus: only ch0 strobes before the trigger; ch2 strobes 0x7FFF in the trigger cycle.
  - response: ch1 resends its previous value; ch2 sends 0x7FFF; `stale_out`=010.
- Overrun:
  - stimulus: tready=0, then a second frame_trigger during SEND.
  - response: `overrun_out`=1 and stays 1; exactly 3 beats sent; the next frame starts only from a later trigger in IDLE.
- Output demux:
  - stimulus: FIR model returns 0xAAAA, 0xBBBB, 0x8000 on separate cycles.
  - response: `filtered_out` = {0x8000,0xBBBB,0xAAAA}; one `filtered_valid_out` pulse one cycle after the 0x8000 beat.
- Reset mid-frame:
  - stimulus: rst_in asserted after the ch0 beat.
  - response: all outputs 0 the next cycle; the following trigger restarts at ch0 with rx_ch=0.
